// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - request/execute/result sequencer around an external 2-bit ALU
module alu_op_sequencer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_a,
   input  logic [1:0]       in_b,
   input  logic [2:0]       in_sel,
   output logic [1:0]       alu_a,
   output logic [1:0]       alu_b,
   output logic [2:0]       alu_sel,
   input  logic [1:0]       alu_out,
   input  logic             alu_carry,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       out_result,
   output logic             out_carry,
   output logic [2:0]       out_sel,
   output logic             out_illegal,
   output logic [CNT_W-1:0] op_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         alu_a       <= 2'b00;
         alu_b       <= 2'b00;
         alu_sel     <= 3'b000;
         out_result  <= 2'b00;
         out_carry   <= 1'b0;
         out_sel     <= 3'b000;
         out_illegal <= 1'b0;
         op_count    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  alu_a    <= in_a;
                  alu_b    <= in_b;
                  alu_sel  <= in_sel;
                  in_ready <= 1'b0;
                  state    <= EXEC;
               end
            end
            EXEC: begin
               // The ALU leaves its carry untouched on logic ops, so it is only trusted for add/sub.
               out_sel <= alu_sel;
               case (alu_sel)
                  3'b000, 3'b001: begin
                     out_result  <= alu_out;
                     out_carry   <= alu_carry;
                     out_illegal <= 1'b0;
                  end
                  3'b010, 3'b011, 3'b100: begin
                     out_result  <= alu_out;
                     out_carry   <= 1'b0;
                     out_illegal <= 1'b0;
                  end
                  default: begin
                     out_result  <= 2'b00;
                     out_carry   <= 1'b0;
                     out_illegal <= 1'b1;
                  end
               endcase
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  op_count  <= op_count + 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule
